rv_lsu: RTL and testbench

Load/store unit between the execute stage and `rv_data_mem`. Accepts one byte-addressed RV64 load or store per request and applies the access size from `funct3`. Drives the 64-bit-wide, word-addressed data memory port. Sub-doubleword stores use a read-modify-write sequence because the memory has no byte enables. Loads return aligned, sign- or zero-extended results.

---
 rtl/rv_lsu.sv | 190 +++++++++++++++++++
 tb/tb_rv_lsu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu.sv
// rv_lsu: RV64 load/store unit between the execute stage and a 4096 x 64-bit
// word-addressed data memory without byte enables.
// Loads are extracted from the read word and then sign- or zero-extended.
// Sub-doubleword stores use a read-modify-write sequence. SD writes directly.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake; ready only in IDLE
//   req_we, req_funct3          store flag and RV access size/sign encoding
//   req_addr, req_wdata         byte address (bits 14:3 select the word), store data
//   rsp_valid, rsp_rdata        one-cycle completion pulse and load result
//   rsp_err                     illegal funct3 (or misalignment when checked)
//   mem_addr                    word address to the data memory
//   mem_wr_en, mem_wr_data      memory write strobe and full-word data
//   mem_rd_en, mem_rd_data      memory read strobe; data returns one cycle later
//
// Optional feature: define RV_LSU_MISALIGN_CHK_EN to reject misaligned H/W/D
// accesses. Without it, the low offset bits are dropped and the access
// proceeds aligned.
module rv_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [11:0] mem_addr,
    output logic        mem_wr_en,
    output logic [63:0] mem_wr_data,
    output logic        mem_rd_en,
    input  logic [63:0] mem_rd_data
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 12;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_ERR} state_t;

    state_t            state;
    logic              a_we;
    logic              a_uns;
    logic [1:0]        a_size;
    logic [2:0]        a_off;
    logic [AW-1:0]     a_word;
    logic [XLEN-1:0]   a_wdata;

    logic              req_illegal;
    logic              req_err;
    logic [2:0]        low_mask;
    logic [2:0]        req_off;
    logic              unused_addr_hi;

    logic [5:0]        sh;
    logic [XLEN-1:0]   size_mask;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   ld_val;
    logic [XLEN-1:0]   merged;

    // Bits above 14 select nothing; the address space wraps modulo 32 KiB.
    assign unused_addr_hi = ^req_addr[63:15];

    // Request classification at acceptance time
    always_comb begin
        req_illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
        case (req_funct3[1:0])
            2'd0:    low_mask = 3'b000;
            2'd1:    low_mask = 3'b001;
            2'd2:    low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
`ifdef RV_LSU_MISALIGN_CHK_EN
        req_err = req_illegal | (|(req_addr[2:0] & low_mask));
        req_off = req_addr[2:0];
`else
        req_err = req_illegal;
        req_off = req_addr[2:0] & ~low_mask;
`endif
    end

    // Load extraction/extension and store merge from the read word
    always_comb begin
        sh      = {a_off, 3'b000};
        shifted = mem_rd_data >> sh;
        case (a_size)
            2'd0: begin
                size_mask = 64'h0000_0000_0000_00FF;
                ld_val    = a_uns ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
            end
            2'd1: begin
                size_mask = 64'h0000_0000_0000_FFFF;
                ld_val    = a_uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            end
            2'd2: begin
                size_mask = 64'h0000_0000_FFFF_FFFF;
                ld_val    = a_uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            end
            default: begin
                size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                ld_val    = shifted;
            end
        endcase
        merged = (mem_rd_data & ~(size_mask << sh)) | ((a_wdata & size_mask) << sh);
    end

    // Load data is only valid while the memory word is on mem_rd_data.
    assign rsp_rdata = (state == S_WAIT && !a_we) ? ld_val : '0;

    // Sequencer; registered outputs describe the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            a_we        <= 1'b0;
            a_uns       <= 1'b0;
            a_size      <= '0;
            a_off       <= '0;
            a_word      <= '0;
            a_wdata     <= '0;
        end else begin
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        a_we    <= req_we;
                        a_uns   <= req_funct3[2];
                        a_size  <= req_funct3[1:0];
                        a_off   <= req_off;
                        a_word  <= req_addr[14:3];
                        a_wdata <= req_wdata;
                        if (req_err) begin
                            state     <= S_ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_we && req_funct3[1:0] == 2'd3) begin
                            state       <= S_WR;
                            mem_wr_en   <= 1'b1;
                            mem_addr    <= req_addr[14:3];
                            mem_wr_data <= req_wdata;
                            rsp_valid   <= 1'b1;
                        end else begin
                            state     <= S_RD;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= req_addr[14:3];
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_RD: begin
                    state     <= S_WAIT;
                    rsp_valid <= !a_we;
                end
                S_WAIT: begin
                    if (a_we) begin
                        state       <= S_WR;
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= a_word;
                        mem_wr_data <= merged;
                        rsp_valid   <= 1'b1;
                    end else begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_lsu.sv
// Bench for rv_lsu: behavioural data memory, byte-level reference model and a
// per-cycle compare of every DUT output against the model's expectation.
module tb_rv_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] mem_addr;
    logic        mem_wr_en;
    logic [63:0] mem_wr_data;
    logic        mem_rd_en;
    logic [63:0] mem_rd_data;

    rv_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

`ifdef RV_LSU_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // Data memory: synchronous read, one-cycle latency
    logic [63:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Reference model: flat 32 KiB byte array
    logic [7:0] mb [0:32767];

    typedef struct packed {
        logic        ready;
        logic        rv;
        logic        err;
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } exp_t;

    exp_t exp_o;
    bit   cmp_on = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk64("req_ready",   64'(req_ready),   64'(exp_o.ready));
            chk64("rsp_valid",   64'(rsp_valid),   64'(exp_o.rv));
            chk64("rsp_err",     64'(rsp_err),     64'(exp_o.err));
            chk64("mem_rd_en",   64'(mem_rd_en),   64'(exp_o.rd));
            chk64("mem_wr_en",   64'(mem_wr_en),   64'(exp_o.wr));
            chk64("mem_addr",    64'(mem_addr),    64'(exp_o.addr));
            chk64("mem_wr_data", mem_wr_data,      exp_o.wdata);
            chk64("rsp_rdata",   rsp_rdata,        exp_o.rdata);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        exp_o = '0;
        exp_o.ready = 1'b1;
    endtask

    task automatic preload(input logic [11:0] w, input logic [63:0] v);
        logic [14:0] base;
        base = {w, 3'b000};
        mem[w] <= v;
        for (int i = 0; i < 8; i++) mb[base + 15'(i)] = v[8*i +: 8];
    endtask

    // One request through its full timeline; res = load result or stored word
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input bit abort_wait,
                          output logic [63:0] res);
        int          n;
        bit          illegal, mis, err;
        logic [2:0]  off;
        logic [11:0] word;
        logic [14:0] base;
        logic [14:0] wbase;
        logic [63:0] val;
        n       = 1 << f3[1:0];
        illegal = we ? f3[2] : (f3 == 3'b111);
        off     = addr[2:0];
        mis     = (int'(off) % n) != 0;
        err     = illegal || (CHK && mis);
        if (!CHK) off = 3'(int'(off) - (int'(off) % n));
        word  = addr[14:3];
        wbase = {word, 3'b000};
        base  = {word, off};
        res   = '0;

        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        step;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};

        exp_o = '0;
        if (err) begin
            exp_o.rv = 1'b1; exp_o.err = 1'b1;
            step;
        end else if (we && n == 8) begin
            for (int i = 0; i < 8; i++) mb[wbase + 15'(i)] = wd[8*i +: 8];
            for (int i = 0; i < 8; i++) res[8*i +: 8] = mb[wbase + 15'(i)];
            exp_o.wr = 1'b1; exp_o.addr = word; exp_o.wdata = res; exp_o.rv = 1'b1;
            step;
        end else if (!we) begin
            exp_o.rd = 1'b1; exp_o.addr = word;
            step;
            val = '0;
            for (int i = 0; i < n; i++) val[8*i +: 8] = mb[base + 15'(i)];
            if (!f3[2] && n < 8 && val[8*n-1])
                for (int j = 8*n; j < 64; j++) val[j] = 1'b1;
            res = val;
            exp_o = '0; exp_o.rv = 1'b1; exp_o.rdata = val;
            step;
        end else begin
            exp_o.rd = 1'b1; exp_o.addr = word;
            step;
            exp_o = '0;
            if (abort_wait) begin
                rst_n = 1'b0;
                step;
                rst_n = 1'b1;
                step;
            end else begin
                step;
                for (int i = 0; i < n; i++) mb[base + 15'(i)] = wd[8*i +: 8];
                for (int i = 0; i < 8; i++) res[8*i +: 8] = mb[wbase + 15'(i)];
                exp_o.wr = 1'b1; exp_o.addr = word; exp_o.wdata = res; exp_o.rv = 1'b1;
                step;
            end
        end
        set_idle;
    endtask

    logic [63:0] r;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        for (int i = 0; i < 32768; i++) mb[i] = '0;
        mem_rd_data = '0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;
        exp_o = '0;
        step; step;
        cmp_on = 1'b1;
        step;
        rst_n = 1'b1;
        step;
        set_idle;
        step;

        // SD then LD of the same doubleword
        do_req(1'b1, 3'b011, 64'h40, 64'h1122334455667788, 1'b0, r);
        chk64("sd_word", r, 64'h1122334455667788);
        do_req(1'b0, 3'b011, 64'h40, 64'h0, 1'b0, r);
        chk64("ld_0x40", r, 64'h1122334455667788);

        // SB into an all-ones word
        preload(12'd8, 64'hFFFF_FFFF_FFFF_FFFF);
        step;
        do_req(1'b1, 3'b000, 64'h43, 64'h00, 1'b0, r);
        chk64("sb_merge", r, 64'hFFFF_FFFF_00FF_FFFF);

        // Sign/zero extension
        preload(12'd8, 64'h0000_0000_80FF_0000);
        step;
        do_req(1'b0, 3'b000, 64'h42, 64'h0, 1'b0, r);
        chk64("lb_0x42", r, 64'hFFFF_FFFF_FFFF_FFFF);
        do_req(1'b0, 3'b100, 64'h42, 64'h0, 1'b0, r);
        chk64("lbu_0x42", r, 64'h0000_0000_0000_00FF);
        do_req(1'b0, 3'b010, 64'h40, 64'h0, 1'b0, r);
        chk64("lw_0x40", r, 64'hFFFF_FFFF_80FF_0000);
        do_req(1'b0, 3'b110, 64'h40, 64'h0, 1'b0, r);
        chk64("lwu_0x40", r, 64'h0000_0000_80FF_0000);

        // Misaligned LW: error when checked, aligned read otherwise
        do_req(1'b0, 3'b010, 64'h42, 64'h0, 1'b0, r);
        chk64("lw_0x42", r, CHK ? 64'h0 : 64'hFFFF_FFFF_80FF_0000);

        // Illegal funct3 in both directions
        do_req(1'b0, 3'b111, 64'h40, 64'h0, 1'b0, r);
        chk64("ld_f3_111", r, 64'h0);
        do_req(1'b1, 3'b100, 64'h40, 64'h55, 1'b0, r);
        chk64("st_f3_100", r, 64'h0);

        // SW / LW / LHU in another word, then address wrap above bit 14
        do_req(1'b1, 3'b010, 64'h104, 64'h0123_4567_DEAD_BEEF, 1'b0, r);
        chk64("sw_0x104", r, 64'hDEAD_BEEF_0000_0000);
        do_req(1'b0, 3'b010, 64'h104, 64'h0, 1'b0, r);
        chk64("lw_0x104", r, 64'hFFFF_FFFF_DEAD_BEEF);
        do_req(1'b0, 3'b101, 64'h106, 64'h0, 1'b0, r);
        chk64("lhu_0x106", r, 64'h0000_0000_0000_DEAD);
        do_req(1'b0, 3'b011, 64'hFFFF_0000_0000_8040, 64'h0, 1'b0, r);
        chk64("ld_wrap", r, 64'h0000_0000_80FF_0000);

        // SH at an odd offset: error when checked, forced to 0x44 otherwise
        do_req(1'b1, 3'b001, 64'h45, 64'hBEEF_A5C3, 1'b0, r);
        chk64("sh_0x45", r, CHK ? 64'h0 : 64'h0000_A5C3_80FF_0000);
        if (!CHK) preload(12'd8, 64'h0000_0000_80FF_0000);
        step;

        // Reset during WAIT of an SH aborts the write
        do_req(1'b1, 3'b001, 64'h40, 64'hAAAA, 1'b1, r);
        chk64("mem_unchanged", mem[8], 64'h0000_0000_80FF_0000);
        do_req(1'b0, 3'b001, 64'h40, 64'h0, 1'b0, r);
        chk64("lh_after_rst", r, 64'h0);
        step;

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
